// File: rtl/spi_slave_rx_pkg.sv
// Shared definitions for the SPI receive endpoint.
// FSM encoding, default sizes and the SPI mode this receiver speaks.
package spi_slave_rx_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    localparam int DATA_WIDTH_DEF  = 8;
    localparam int SYNC_STAGES_DEF = 2;

    // Mode 3: SCLK idles high, data sampled on the rising edge
    localparam logic SPI_CPOL    = 1'b1;
    localparam logic SAMPLE_RISE = 1'b1;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop bit synchroniser with a configurable reset value.
// The reset value is chosen to match the idle level of the pin.
module spi_sync
    import spi_slave_rx_pkg::*;
#(
    parameter int   STAGES  = SYNC_STAGES_DEF,
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic D,
    output logic Q
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ff_q <= {STAGES{RST_VAL}};
        end else begin
            ff_q <= {ff_q[STAGES-2:0], D};
        end
    end

    assign Q = ff_q[STAGES-1];

endmodule

// File: rtl/spi_slave_rx.sv
// SPI peripheral-side receiver: oversampled pins, MSB-first shifter,
// one-deep valid/ready output buffer with sticky overrun.
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CS,
    input  logic                  SCLK,
    input  logic                  SDI,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  RX_VALID,
    input  logic                  RX_READY,
    output logic                  RX_OVERRUN,
    input  logic                  OVR_CLR,
    output logic                  BYTE_ABORT,
    output logic                  FRAME_ACTIVE
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_WIDTH - 1);

    logic cs_s;
    logic sclk_s;
    logic sdi_s;
    logic sclk_d;
    logic rise;
    logic accept;
    logic primed;

    logic [SYNC_STAGES-1:0] prime_q;
    logic                   armed_q, armed_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic                   done_q, done_d;
    logic                   abort_q, abort_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ovr_q, ovr_d;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .CLK(CLK), .RST_N(RST_N), .D(CS), .Q(cs_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sync_sclk (
        .CLK(CLK), .RST_N(RST_N), .D(SCLK), .Q(sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sdi (
        .CLK(CLK), .RST_N(RST_N), .D(SDI), .Q(sdi_s)
    );

    assign rise   = SAMPLE_RISE ? (sclk_s & ~sclk_d) : (~sclk_s & sclk_d);
    assign accept = valid_q & RX_READY;
    // cs_s only reflects the pin once reset values have left the synchroniser
    assign primed = prime_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        armed_d = armed_q | (primed & cs_s);
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (armed_q && !cs_s) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    abort_d = (cnt_q != '0);
                end else if (rise) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], sdi_s};
                    if (cnt_q == LAST) begin
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase

        if (OVR_CLR) begin
            ovr_d = 1'b0;
        end

        if (done_q) begin
            if (!valid_q || accept) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sclk_d  <= SPI_CPOL;
            prime_q <= '0;
            armed_q <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sclk_d  <= sclk_s;
            prime_q <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            armed_q <= armed_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign RX_DATA      = data_q;
    assign RX_VALID     = valid_q;
    assign RX_OVERRUN   = ovr_q;
    assign BYTE_ABORT   = abort_q;
    assign FRAME_ACTIVE = (state_q == ST_ACTIVE);

endmodule
